sqrt_scheduler: RTL and testbench

Round-robin scheduler that shares one `square_extractor` (integer square root, `dout`/`remainder` outputs, no handshake) among `NUM_REQ` requesters. It accepts one radicand at a time through per-requester valid/ready ports. It holds the radicand stable on the extractor for a fixed `LATENCY` window, then returns root, remainder and requester ID on a single valid/ready response channel. It sits between client blocks and the shared extractor instance, which it instantiates internally.

---
 rtl/sqrt_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_sqrt_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_scheduler.sv
// Round-robin front end that time-shares one integer square-root extractor
// among NUM_REQ requesters and returns root, remainder and requester ID.

module square_extractor #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*WIDTH-1:0] din,
    output logic [WIDTH-1:0]   dout,
    output logic [2*WIDTH-1:0] remainder
);
    logic [2*WIDTH+1:0] rem_v;
    logic [2*WIDTH+1:0] trial_v;
    logic [WIDTH-1:0]   root_v;
    logic [WIDTH-1:0]   dout_q;
    logic [2*WIDTH-1:0] rem_q;

    // NOTE: blocking assignments here are deliberate; each loop pass must see
    // the partial root/remainder produced by the previous pass.
    always_comb begin
        rem_v   = '0;
        trial_v = '0;
        root_v  = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            rem_v   = {rem_v[2*WIDTH-1:0], din[2*i +: 2]};
            trial_v = (2*WIDTH+2)'({root_v, 2'b01});
            if (rem_v >= trial_v) begin
                rem_v  = rem_v - trial_v;
                root_v = (root_v << 1) | WIDTH'(1);
            end else begin
                root_v = root_v << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            rem_q  <= '0;
        end else begin
            dout_q <= root_v;
            rem_q  <= rem_v[2*WIDTH-1:0];
        end
    end

    assign dout      = dout_q;
    assign remainder = rem_q;
endmodule

module sqrt_scheduler #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 3,
    parameter int LATENCY = 4 * WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*2*WIDTH-1:0] req_radicand,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH-1:0]           rsp_root,
    output logic [2*WIDTH-1:0]         rsp_remainder,
    output logic                       busy
);
    localparam int RAD_W = 2 * WIDTH;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t             state_q;
    logic [RAD_W-1:0]   radicand_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [WIDTH-1:0]   rsp_root_q;
    logic [RAD_W-1:0]   rsp_rem_q;
    logic               busy_q;

    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] grant_oh;
    logic [RAD_W-1:0]   grant_radicand;
    logic [ID_W:0]      search_idx;
    logic [WIDTH-1:0]   ext_dout;
    logic [RAD_W-1:0]   ext_rem;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant_found    = 1'b0;
        grant_id       = '0;
        grant_oh       = '0;
        grant_radicand = '0;
        search_idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            search_idx = {1'b0, last_grant_q} + (ID_W+1)'(k);
            if (search_idx >= (ID_W+1)'(NUM_REQ))
                search_idx = search_idx - (ID_W+1)'(NUM_REQ);
            if (!grant_found && req_valid[search_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = search_idx[ID_W-1:0];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_found && grant_id == ID_W'(i)) begin
                grant_oh[i]    = 1'b1;
                grant_radicand = req_radicand[i*RAD_W +: RAD_W];
            end
        end
    end

    // Gated by rst_n so no requester sees a handshake while reset is held.
    assign req_ready = (state_q == IDLE && rst_n) ? grant_oh : '0;

    square_extractor #(.WIDTH(WIDTH)) u_extractor (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (radicand_q),
        .dout      (ext_dout),
        .remainder (ext_rem)
    );

    // NOTE: every piece of sequential state, including the radicand holding
    // register, is reset here so an aborted job leaves no residue behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            radicand_q   <= '0;
            id_q         <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_root_q   <= '0;
            rsp_rem_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        radicand_q   <= grant_radicand;
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        cnt_q        <= CNT_W'(LATENCY - 1);
                        state_q      <= RUN;
                        busy_q       <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        rsp_root_q  <= ext_dout;
                        rsp_rem_q   <= ext_rem;
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_root      = rsp_root_q;
    assign rsp_remainder = rsp_rem_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_sqrt_scheduler.sv
// Directed and randomized checks of sqrt_scheduler with its default
// parameters (WIDTH=4, NUM_REQ=3, LATENCY=16).

module tb_sqrt_scheduler;
    localparam int WIDTH   = 4;
    localparam int NUM_REQ = 3;
    localparam int RAD_W   = 2 * WIDTH;
    localparam int ID_W    = 2;
    localparam int N_RND   = 1000;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*RAD_W-1:0] req_radicand;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_root;
    logic [RAD_W-1:0]         rsp_remainder;
    logic                     busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int id;
        int rad;
    } job_t;

    job_t exp_q[$];

    sqrt_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_radicand  (req_radicand),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_root      (rsp_root),
        .rsp_remainder (rsp_remainder),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int oh_index(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns one time unit after the accept edge, i.e. in RUN cycle 1.
    task automatic wait_grant(input string tag, input int budget, output int g);
        g = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = oh_index(req_ready);
                check({tag, "_onehot"}, 32'($onehot(req_ready)), 1);
                break;
            end
        end
        if (g < 0) check({tag, "_grant_seen"}, 0, 1);
        tick();
    endtask

    // Returns at the negedge where rsp_valid is first seen; n counts negedges.
    task automatic wait_rsp(input string tag, input int budget, output int n);
        n = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) check({tag, "_rsp_seen"}, 0, 1);
    endtask

    task automatic set_rad(input int i, input int v);
        req_radicand[i*RAD_W +: RAD_W] = RAD_W'(v);
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int g, n, seen;
        int acc[3];
        int last_g, accepted, responded, budget, npend;
        logic [NUM_REQ-1:0] taken;
        job_t j;

        rst_n        = 1'b0;
        req_valid    = '0;
        req_radicand = '0;
        rsp_ready    = 1'b1;
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_root", rsp_root, 0);
        check("rst_rsp_rem", rsp_remainder, 0);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;

        // Single request: 200 -> root 14, remainder 4.
        set_rad(0, 200);
        req_valid = 3'b001;
        wait_grant("t1", 10, g);
        req_valid = '0;
        check("t1_grant", g, 0);
        @(negedge clk);
        check("t1_busy_run", busy, 1);
        check("t1_ready_run", req_ready, 0);
        wait_rsp("t1", 40, n);
        check("t1_latency", n + 1, 17);
        check("t1_id", rsp_id, 0);
        check("t1_root", rsp_root, 14);
        check("t1_rem", rsp_remainder, 4);
        tick();
        @(negedge clk);
        check("t1_valid_drop", rsp_valid, 0);
        check("t1_busy_idle", busy, 0);

        // Simultaneous requests held from reset.
        rst_n = 1'b0;
        set_rad(0, 0);
        set_rad(1, 255);
        set_rad(2, 144);
        req_valid = 3'b111;
        #3;
        check("t2_ready_in_reset", req_ready, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_grant("t2", 40, g);
            acc[k] = cyc;
            check("t2_order", g, k);
            if (g >= 0) req_valid[g] = 1'b0;
            wait_rsp("t2", 40, n);
            check("t2_id", rsp_id, k);
            check("t2_root", rsp_root, (k == 0) ? 0 : (k == 1) ? 15 : 12);
            check("t2_rem", rsp_remainder, (k == 0) ? 0 : (k == 1) ? 30 : 0);
        end
        check("t2_gap01", acc[1] - acc[0], 18);
        check("t2_gap12", acc[2] - acc[1], 18);

        // Fairness: 0 and 2 always valid, 1 idle.
        set_rad(0, 49);
        set_rad(2, 100);
        req_valid = 3'b101;
        for (int k = 0; k < 4; k++) begin
            wait_grant("t3", 40, g);
            check("t3_grant", g, (k % 2 == 0) ? 0 : 2);
            wait_rsp("t3", 40, n);
            check("t3_root", rsp_root, (k % 2 == 0) ? 7 : 10);
        end
        req_valid = '0;
        @(negedge clk);

        // Backpressure with requester 1 pending.
        tick();
        rsp_ready = 1'b0;
        set_rad(0, 81);
        set_rad(1, 10);
        req_valid = 3'b011;
        wait_grant("t4", 10, g);
        check("t4_grant", g, 0);
        req_valid[0] = 1'b0;
        wait_rsp("t4", 40, n);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("t4_hold_valid", rsp_valid, 1);
            check("t4_hold_id", rsp_id, 0);
            check("t4_hold_root", rsp_root, 9);
            check("t4_hold_rem", rsp_remainder, 0);
            check("t4_hold_ready", req_ready, 0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_hold_last", rsp_valid, 1);
        check("t4_ready_resp", req_ready, 0);
        @(negedge clk);
        check("t4_next_accept", req_ready, 3'b010);
        tick();
        req_valid = '0;
        wait_rsp("t4", 40, n);
        check("t4_id2", rsp_id, 1);
        check("t4_root2", rsp_root, 3);
        check("t4_rem2", rsp_remainder, 1);
        @(negedge clk);

        // Reset in the middle of RUN.
        tick();
        set_rad(0, 50);
        req_valid = 3'b001;
        wait_grant("t5", 10, g);
        req_valid = '0;
        repeat (7) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_ready", req_ready, 0);
        check("t5_valid", rsp_valid, 0);
        check("t5_root", rsp_root, 0);
        check("t5_rem", rsp_remainder, 0);
        check("t5_id", rsp_id, 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("t5_no_rsp", seen, 0);
        tick();
        set_rad(0, 36);
        set_rad(1, 20);
        req_valid = 3'b011;
        wait_grant("t5", 10, g);
        check("t5_first", g, 0);
        req_valid = '0;
        wait_rsp("t5", 40, n);
        check("t5_root2", rsp_root, 6);
        check("t5_rem2", rsp_remainder, 0);

        // Random regression against a round-robin and brute-force root model.
        apply_reset();
        last_g    = NUM_REQ - 1;
        accepted  = 0;
        responded = 0;
        budget    = 0;
        while (responded < N_RND && budget < 60000) begin
            @(negedge clk);
            budget++;
            taken = '0;
            if (req_ready != '0) begin
                g = oh_index(req_ready);
                check("rnd_grant", g, rr_pick(last_g, req_valid));
                j.id  = g;
                j.rad = int'(req_radicand[g*RAD_W +: RAD_W]);
                exp_q.push_back(j);
                last_g   = g;
                taken[g] = 1'b1;
                accepted++;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious", 1, 0);
                end else begin
                    j = exp_q.pop_front();
                    check("rnd_id", rsp_id, j.id);
                    check("rnd_root", rsp_root, isqrt(j.rad));
                    check("rnd_rem", rsp_remainder, j.rad - isqrt(j.rad) * isqrt(j.rad));
                    check("rnd_sum", int'(rsp_root) * int'(rsp_root) + int'(rsp_remainder), j.rad);
                    check("rnd_rem_bound", 32'(int'(rsp_remainder) <= 2 * int'(rsp_root)), 1);
                end
                responded++;
            end
            tick();
            req_valid = req_valid & ~taken;
            npend = 0;
            for (int i = 0; i < NUM_REQ; i++) if (req_valid[i]) npend++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && accepted + npend < N_RND && $urandom_range(0, 2) == 0) begin
                    set_rad(i, int'($urandom_range(0, 255)));
                    req_valid[i] = 1'b1;
                    npend++;
                end else if (req_valid[i] && $urandom_range(0, 63) == 0) begin
                    req_valid[i] = 1'b0;
                    npend--;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        check("rnd_accepts", accepted, N_RND);
        check("rnd_responses", responded, N_RND);
        check("rnd_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
